// File: rtl/adder_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor. The chain of 4-bit CLA groups is cut
// into N_STAGE register stages under one global stall (adv).
module adder_cla_pipe #(
   parameter int BW_DATA = 32,
   parameter int N_STAGE = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [BW_DATA-1:0] i_a,
   input  logic [BW_DATA-1:0] i_b,
   input  logic               i_c,
   input  logic               i_sub,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [BW_DATA-1:0] o_s,
   output logic               o_c,
   output logic               o_ovf
);

   localparam int GRP = BW_DATA / 4;
   localparam int GPS = GRP / N_STAGE;
   localparam int W   = 4 * GPS;

   // One 4-bit lookahead group: returns {carry_out, sum[3:0]}.
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      return {c[4], p ^ c[3:0]};
   endfunction

   logic               adv;
   logic               cmsb;
   logic [BW_DATA-1:0] b_op;
   logic               cin;

   assign b_op = i_sub ? ~i_b : i_b;
   assign cin  = i_sub | i_c;

   for (genvar k = 0; k < N_STAGE; k++) begin : g_stage
      localparam int REM = BW_DATA - k * W;

      logic [REM-1:0]       a_all;
      logic [REM-1:0]       b_all;
      logic                 carry;
      logic                 vld_src;
      logic [W-1:0]         s_cur;
      logic                 c_out;
      logic [(k+1)*W-1:0]   sum_nx;
      logic                 vld;
      logic                 cy;
      logic [(k+1)*W-1:0]   sum;

      if (k == 0) begin : g_src
         assign a_all   = i_a;
         assign b_all   = b_op;
         assign carry   = cin;
         assign vld_src = i_valid;
         assign sum_nx  = s_cur;
      end else begin : g_src
         assign a_all   = g_stage[k-1].g_rem.a_rem;
         assign b_all   = g_stage[k-1].g_rem.b_rem;
         assign carry   = g_stage[k-1].cy;
         assign vld_src = g_stage[k-1].vld;
         assign sum_nx  = {s_cur, g_stage[k-1].sum};
      end

      always_comb begin
         logic       c_run;
         logic [4:0] r;
         c_run = carry;
         r     = '0;
         s_cur = '0;
         for (int j = 0; j < GPS; j++) begin
            r                = cla4(a_all[4*j +: 4], b_all[4*j +: 4], c_run);
            s_cur[4*j +: 4]  = r[3:0];
            c_run            = r[4];
         end
         c_out = c_run;
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            vld <= 1'b0;
            cy  <= 1'b0;
            sum <= '0;
         end else if (adv) begin
            vld <= vld_src;
            cy  <= c_out;
            sum <= sum_nx;
         end
      end

      if (k < N_STAGE - 1) begin : g_rem
         // Operand slices still waiting for a later stage.
         logic [REM-W-1:0] a_rem;
         logic [REM-W-1:0] b_rem;
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               a_rem <= '0;
               b_rem <= '0;
            end else if (adv) begin
               a_rem <= a_all[REM-1:W];
               b_rem <= b_all[REM-1:W];
            end
         end
      end else begin : g_last
         // Carry into the MSB recovered from sum ^ a ^ b at the top bit.
         always_ff @(posedge i_clk) begin
            if (i_rst)    cmsb <= 1'b0;
            else if (adv) cmsb <= a_all[W-1] ^ b_all[W-1] ^ s_cur[W-1];
         end
      end
   end

   assign o_valid = g_stage[N_STAGE-1].vld;
   assign o_c     = g_stage[N_STAGE-1].cy;
   assign o_s     = g_stage[N_STAGE-1].sum;
   assign o_ovf   = cmsb ^ o_c;
   assign adv     = ~o_valid | i_ready;
   assign o_ready = adv;

endmodule

// File: doc/adder_cla_pipe.md
# adder_cla_pipe

Pipelined, parametrised carry-lookahead adder/subtractor with valid/ready flow control. The carry chain of 4-bit CLA groups is split across `N_STAGE` register stages, so wide operands close timing at high clock rates. Each accepted operand pair produces one result `N_STAGE` cycles later. The block sits in the datapath wherever a registered add/sub with backpressure is needed, for example in accumulators or address generators.

## Interface
- `BW_DATA`, default 32: operand and result width. Must be a multiple of 4.
- `N_STAGE`, default 2: number of pipeline stages. Must be at least 1 and divide `BW_DATA/4`.
- `i_clk`, input, 1: clock. All logic updates on the rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_valid`, input, 1: operand pair present on `i_a`, `i_b`, `i_c`, `i_sub`.
- `o_ready`, output, 1: block can accept an operand pair this cycle.
- `i_a`, input, `BW_DATA`: operand A.
- `i_b`, input, `BW_DATA`: operand B.
- `i_c`, input, 1: carry-in. Ignored when `i_sub`=1.
- `i_sub`, input, 1: 0 = A+B+`i_c`; 1 = A−B (A + ~B + 1).
- `o_valid`, output, 1: result present on `o_s`, `o_c`, `o_ovf`.
- `i_ready`, input, 1: downstream accepts the result this cycle.
- `o_s`, output, `BW_DATA`: sum or difference.
- `o_c`, output, 1: carry-out of the MSB. In subtract mode, 1 = no borrow.
- `o_ovf`, output, 1: signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- `GRP = BW_DATA/4` CLA groups. `GPS = GRP/N_STAGE` groups per stage.
- Stage k (0..N_STAGE−1) resolves groups k·GPS .. (k+1)·GPS−1 using a ripple of 4-bit CLA groups seeded by the carry registered from stage k−1. Stage 0 is seeded by `i_c`, or by 1 when `i_sub`=1.
- `i_b` is inverted at stage-0 entry when `i_sub`=1.
- Per-stage registers:
  - valid bit
  - carry
  - sum bits resolved so far
  - not-yet-consumed slices of A and B'
  - carry into MSB, captured only by the last stage.
- Width rules:
  - result is modulo 2^`BW_DATA`.
  - `o_c` = bit `BW_DATA` of the full-width A+B'+cin.
  - `o_ovf` = cin_msb ^ cout_msb.
- Flow control uses a global stall:
  - `adv = ~o_valid | i_ready`
  - `o_ready = adv`
- When `adv`=1, every stage register loads from its predecessor. Stage 0 loads `i_valid` and the operands. When `adv`=0, all stage registers hold.
- An input is accepted when `i_valid & o_ready`. An output is consumed when `o_valid & i_ready`.
- A bubble (`i_valid`=0 while `adv`=1) propagates as a zero valid bit. Operand registers may load don't-care data.
- Output ports are driven directly from the last-stage registers. They stay stable while `o_valid & ~i_ready`.
- `N_STAGE`=1 degenerates to a single registered full-width CLA.

## Timing
- Reset (`i_rst`=1 at a rising edge):
  - all valid bits = 0, all data registers = 0.
  - after the edge: `o_valid`=0, `o_s`=0, `o_c`=0, `o_ovf`=0, `o_ready`=1.
- Reset mid-operation discards all in-flight results. No result emerges after reset.
- Latency: an operand pair accepted at edge t appears with `o_valid`=1 after edge t+N_STAGE−1, i.e. visible in the cycle following N_STAGE accepting edges, provided no stall occurs.
- Throughput: one result per cycle while `i_ready`=1.
- Stall: if `o_valid`=1 and `i_ready`=0, then `o_ready`=0 combinationally in the same cycle. No input is accepted and no stage changes.
- Simultaneous events:
  - consume and accept in the same cycle is legal and loses no data.
  - `i_valid` with `o_ready`=0: the upstream source must hold its inputs. The block does not sample them.
- Ordering is strictly in-order. No result is duplicated or dropped.
- `o_ready` depends combinationally on `i_ready`. This is the only combinational input-to-output path.

## Test plan
All scenarios use `BW_DATA`=32 and `N_STAGE`=2 unless stated.
- **Reset:** `i_rst`=1 for 2 cycles while `i_valid`=1 → `o_valid`=0, `o_s`=0, `o_c`=0, `o_ovf`=0 throughout; `o_ready`=1 after release.
- **Carry ripple across stages:** A=0xFFFF_FFFF, B=0x0000_0001, `i_c`=0, `i_sub`=0 → 2 cycles later `o_s`=0x0000_0000, `o_c`=1, `o_ovf`=0. Carry must cross the stage boundary at bit 16.
- **Subtract and overflow:**
  - A=0x8000_0000, B=1, `i_sub`=1 → `o_s`=0x7FFF_FFFF, `o_c`=1, `o_ovf`=1.
  - A=5, B=7, `i_sub`=1 → `o_s`=0xFFFF_FFFE, `o_c`=0, `o_ovf`=0.
- **Backpressure:** stream 6 back-to-back pairs (A=i, B=0x10·i for i=1..6) with `i_ready`=0 in cycles 3–5 → `o_ready`=0 in exactly those cycles. Outputs 0x11, 0x22, …, 0x66 arrive in order, each held stable while stalled, none lost.
- **Reset mid-stream:** assert `i_rst` with 2 results in flight → no `o_valid` pulse appears for them afterwards.
- **Parameter sweep:** (`BW_DATA`, `N_STAGE`) = (8,1), (16,4), (64,8), 10k random pairs each → results match a reference model A+B'+cin, with latency exactly `N_STAGE`.
